// File: rtl/skid_pkg.sv
// Shared definitions for the skid_ready_stage block.
//
// Contents:
//   DEFAULT_DW    - default payload width in bits
//   DEFAULT_CNT_W - default width of the stall-cycle counter
//   sat_inc()     - saturating increment used by sat_counter.
//                   The helper works on 32-bit values, so counters built
//                   on it must be at most 32 bits wide.
package skid_pkg;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_CNT_W = 16;

    // Adds one to value, but never goes past max_value.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//
// The counter adds one on every cycle where i_inc is high. It stops at its
// all-ones value and does not wrap. i_clear is synchronous and has
// priority over i_inc.
//
// Ports:
//   i_clk    input  1  clock (posedge)
//   i_clear  input  1  synchronous clear, active high
//   i_inc    input  1  count this cycle
//   o_count  output W  current count
module sat_counter
    import skid_pkg::*;
#(
    parameter int W = DEFAULT_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_inc) begin
            count_d = W'(sat_inc(32'(count_q), 32'(MAX)));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/skid_ready_stage.sv
// Valid/ready pipeline stage with a registered upstream ready.
//
// o_ready comes straight from a flop, so there is no combinational path
// from i_ready to o_ready. A one-entry skid register catches the beat that
// upstream sends in the same cycle the stall happens, because upstream
// still sees o_ready high in that cycle.
//
// Parameters:
//   DW         payload width
//   OPT_OUTREG 0 = o_valid/o_data are combinational (zero latency),
//              1 = o_valid/o_data are registered (one-cycle latency)
//   CNT_W      width of the saturating stall counter
//
// Ports:
//   i_clk        input  1      clock (posedge)
//   i_reset      input  1      synchronous reset, active high
//   i_valid      input  1      upstream beat valid
//   i_data       input  DW     upstream payload
//   o_ready      output 1      registered upstream ready
//   o_valid      output 1      downstream beat valid
//   o_data       output DW     downstream payload
//   i_ready      input  1      downstream ready
//   o_stall_cnt  output CNT_W  cycles with o_valid && !i_ready (saturating)
//   o_err        output 1      sticky upstream protocol violation
//
// Build option:
//   SKID_READY_PROTO_CHK_EN - when defined, o_err flags a stalled upstream
//   beat that is withdrawn or whose data changes before it is accepted.
//   When not defined, the checker is absent and o_err is tied to 0.
module skid_ready_stage
    import skid_pkg::*;
#(
    parameter int DW         = DEFAULT_DW,
    parameter int OPT_OUTREG = 0,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [DW-1:0]    i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [DW-1:0]    o_data,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic             o_err
);

    logic          r_valid_q;
    logic          r_valid_d;
    logic [DW-1:0] r_data_q;
    logic [DW-1:0] r_data_d;
    logic          ready_q;
    logic          ready_d;
    logic          out_valid_q;
    logic          out_valid_d;
    logic [DW-1:0] out_data_q;
    logic [DW-1:0] out_data_d;

    // Skid and output-register next state. i_ready always wins over a
    // capture, so a draining skid never also loads a new beat; the new
    // beat goes straight through (or into the output register) instead.
    always_comb begin
        r_valid_d   = r_valid_q;
        r_data_d    = r_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (OPT_OUTREG == 0) begin
            if (i_ready) begin
                r_valid_d = 1'b0;
            end else if (i_valid && ready_q) begin
                r_valid_d = 1'b1;
                r_data_d  = i_data;
            end
        end else begin
            if (!out_valid_q || i_ready) begin
                out_valid_d = i_valid || r_valid_q;
                out_data_d  = r_valid_q ? r_data_q : i_data;
            end
            if (i_ready) begin
                r_valid_d = 1'b0;
            end else if (i_valid && ready_q && out_valid_q) begin
                r_valid_d = 1'b1;
                r_data_d  = i_data;
            end
        end

        // Ready for next cycle only if the skid will be empty.
        ready_d = !r_valid_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid_q   <= 1'b0;
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            r_valid_q   <= r_valid_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Payload registers carry no reset; their valid bits guard them.
    always_ff @(posedge i_clk) begin
        r_data_q   <= r_data_d;
        out_data_q <= out_data_d;
    end

    always_comb begin
        o_valid = i_valid || r_valid_q;
        o_data  = r_valid_q ? r_data_q : i_data;
        if (OPT_OUTREG != 0) begin
            o_valid = out_valid_q;
            o_data  = out_data_q;
        end
    end

    assign o_ready = ready_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_clear (i_reset),
        .i_inc   (o_valid && !i_ready),
        .o_count (o_stall_cnt)
    );

`ifdef SKID_READY_PROTO_CHK_EN
    logic          stall_q;
    logic          stall_d;
    logic [DW-1:0] prev_data_q;
    logic [DW-1:0] prev_data_d;
    logic          err_q;
    logic          err_d;

    // A beat that was offered but not taken last cycle must still be
    // offered this cycle with identical data.
    always_comb begin
        stall_d     = i_valid && !ready_q;
        prev_data_d = i_data;
        err_d       = err_q;
        if (stall_q && (!i_valid || (i_data != prev_data_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        prev_data_q <= prev_data_d;
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: doc/skid_ready_stage.md
Name: skid_ready_stage

Overview:
- Valid/ready pipeline stage with full data path whose upstream ready (o_ready) is a register, cutting the combinational i_ready-to-o_ready path.
- Counterpart to the forward-registered valid stage: this block registers the backward (ready) direction.
- Uses a one-entry skid register to absorb the beat accepted while o_ready is still high.
- Sits between any producer/consumer pair on the team's i_valid/o_ready to o_valid/i_ready streaming interface.

Parameters:
- DW, 8, payload width in bits.
- OPT_OUTREG, 0, 0 = combinational output path (zero latency); 1 = o_valid/o_data registered (one-cycle latency).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- i_clk  input  1  clock; all logic on posedge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream beat valid.
- i_data  input  DW  upstream payload.
- o_ready  output  1  registered upstream ready.
- o_valid  output  1  downstream beat valid.
- o_data  output  DW  downstream payload.
- i_ready  input  1  downstream ready.
- o_stall_cnt  output  CNT_W  saturating count of cycles with o_valid && !i_ready.
- o_err  output  1  sticky upstream protocol violation (see Optional Feature).

Behaviour:
- One clock domain, synchronous active-high reset i_reset on i_clk; no asynchronous paths.
- Reset values: r_valid=0, o_ready=0, o_valid=0 (OPT_OUTREG=1), o_stall_cnt=0, o_err=0. r_data and o_data registers are not reset.
- o_ready <= !next_r_valid, and is held 0 while i_reset is high. First beat is accepted no earlier than the cycle after reset deasserts.
- Upstream handshake: a beat transfers when i_valid && o_ready. Downstream handshake: a beat transfers when o_valid && i_ready.
- OPT_OUTREG=0:
  - o_valid = i_valid || r_valid; o_data = r_valid ? r_data : i_data.
  - r_valid set, with r_data <= i_data, when i_valid && o_ready && !i_ready.
  - r_valid cleared when i_ready.
- OPT_OUTREG=1:
  - When !o_valid || i_ready: o_valid <= i_valid || r_valid; o_data <= r_valid ? r_data : i_data.
  - r_valid set, with r_data <= i_data, when i_valid && o_ready && o_valid && !i_ready.
  - r_valid cleared when i_ready.
- Capacity: 1 beat (OPT_OUTREG=0) or 2 beats (OPT_OUTREG=1). Never drops, duplicates or reorders beats.
- Skid full (r_valid=1) implies o_ready=0 on the following cycle. The upstream beat accepted in the same cycle as the stall is always captured.
- Simultaneous capture and drain: i_ready has priority, so the skid is cleared and the new beat passes through (or loads the output register).
- Sustained throughput is 1 beat/cycle with i_ready=1 continuously.
- Reset mid-transfer discards all held beats. o_valid is 0 (OPT_OUTREG=1) or follows i_valid && 0 skid (OPT_OUTREG=0) during reset. o_ready stays 0 until release.
- o_stall_cnt increments on o_valid && !i_ready, saturates at 2^CNT_W-1 with no wrap, and clears only on reset.

Optional Feature:
- Macro: SKID_READY_PROTO_CHK_EN.
- Defined: the block registers the previous-cycle stall condition (i_valid && !o_ready) and the previous i_data. o_err is set sticky when a stalled upstream beat is withdrawn (i_valid falls) or its i_data changes before acceptance. o_err clears only on reset.
- Undefined: checker logic absent; o_err tied 0.

Decomposition:
- Shared package skid_pkg: default DW, CNT_W localparams, and a function for saturating increment.
- No sub-module needed. Optionally factor the stall counter as sat_counter (width-parameterised, inc/clear inputs).

Test Plan:
- Reset release: i_reset high 3 cycles, then low → o_ready=0 during reset and 1 on the first post-reset cycle; o_valid=0, o_stall_cnt=0.
- Streaming, OPT_OUTREG=0, i_ready=1: send 0x01..0x08 back-to-back → o_data identical in the same cycle, 8 beats in 8 cycles, o_stall_cnt=0.
- Stall capture: i_valid=1 with 0xA5 then 0x5A; drop i_ready in the 0xA5 cycle → 0xA5 held in skid, o_ready=0 next cycle. Raise i_ready → 0xA5 then 0x5A delivered in order, none lost.
- OPT_OUTREG=1 random: random i_valid/i_ready at 50% each, 1000 beats with incrementing data → scoreboard exact in-order match, one-cycle minimum latency, o_stall_cnt equals counted stall cycles.
- Saturation: CNT_W=4, i_ready=0 with o_valid=1 for 20 cycles → o_stall_cnt reaches 15 and holds.
- Proto check (macro defined): hold i_valid=1, 0x33 while stalled, then change to 0x34 before acceptance → o_err=1 next cycle and stays 1 until reset. With macro undefined → o_err=0.
